// File: rtl/i2c_txn_sequencer.sv
// Drives one full I2C transaction (START, address, N data bytes, STOP) on the byte
// controller from a single descriptor, streaming write/read data through valid/ready ports.
module i2c_txn_sequencer #(
  parameter int unsigned LEN_W = 4
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             enable_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [6:0]       req_addr_i,
  input  logic             req_rnw_i,
  input  logic [LEN_W-1:0] req_len_i,
  input  logic [7:0]       tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic [7:0]       rx_data_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       status_o,
  output logic             bc_start_o,
  output logic             bc_stop_o,
  output logic             bc_read_o,
  output logic             bc_write_o,
  output logic             bc_ack_o,
  output logic [7:0]       bc_din_o,
  input  logic             bc_cmd_ack_i,
  input  logic             bc_ack_out_i,
  input  logic [7:0]       bc_dout_i,
  input  logic             bc_al_i
);

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned BYTE_W = 8;
  localparam logic [1:0]  ST_OK   = 2'b00;
  localparam logic [1:0]  ST_NACK = 2'b01;
  localparam logic [1:0]  ST_AL   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WAIT_TX, S_WDATA, S_RDATA, S_WAIT_RX, S_STOP, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rnw_q, rnw_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [BYTE_W-1:0]   txb_q, txb_d;
  logic [BYTE_W-1:0]   rxb_q, rxb_d;
  logic [1:0]          status_q, status_d;
  logic                gap_q;
  logic                req_ready_q;

  logic cmd_en;
  logic cmd_ack;
  logic al_hit;
  logic cnt_zero;
  logic cnt_last;

  // gap_q masks commands for the cycle right after a command ack
  assign cmd_en   = !gap_q;
  assign cmd_ack  = bc_cmd_ack_i && cmd_en;
  assign al_hit   = bc_al_i && (state_q != S_IDLE) && (state_q != S_DONE);
  assign cnt_zero = (cnt_q == '0);
  assign cnt_last = (cnt_q == LEN_W'(1));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rnw_q       <= 1'b0;
      cnt_q       <= '0;
      txb_q       <= '0;
      rxb_q       <= '0;
      status_q    <= ST_OK;
      gap_q       <= 1'b0;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rnw_q       <= rnw_d;
      cnt_q       <= cnt_d;
      txb_q       <= txb_d;
      rxb_q       <= rxb_d;
      status_q    <= status_d;
      gap_q       <= cmd_ack;
      req_ready_q <= enable_i && (state_d == S_IDLE);
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rnw_d    = rnw_q;
    cnt_d    = cnt_q;
    txb_d    = txb_q;
    rxb_d    = rxb_q;
    status_d = status_q;
    if (al_hit) begin
      // arbitration loss wins over any simultaneous ack; no STOP is attempted
      state_d  = S_DONE;
      status_d = ST_AL;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i && req_ready_q) begin
            addr_d   = req_addr_i;
            rnw_d    = req_rnw_i;
            cnt_d    = req_len_i;
            status_d = ST_OK;
            state_d  = S_ADDR;
          end
        end
        S_ADDR: begin
          if (cmd_ack) begin
            if (bc_ack_out_i) begin
              status_d = ST_NACK;
              state_d  = cnt_zero ? S_DONE : S_STOP;
            end else if (cnt_zero) begin
              state_d = S_DONE;
            end else begin
              state_d = rnw_q ? S_RDATA : S_WAIT_TX;
            end
          end
        end
        S_WAIT_TX: begin
          if (tx_valid_i) begin
            txb_d   = tx_data_i;
            state_d = S_WDATA;
          end
        end
        S_WDATA: begin
          if (cmd_ack) begin
            cnt_d = cnt_q - LEN_W'(1);
            if (bc_ack_out_i) begin
              status_d = ST_NACK;
              state_d  = cnt_last ? S_DONE : S_STOP;
            end else begin
              state_d = cnt_last ? S_DONE : S_WAIT_TX;
            end
          end
        end
        S_RDATA: begin
          if (cmd_ack) begin
            rxb_d   = bc_dout_i;
            cnt_d   = cnt_q - LEN_W'(1);
            state_d = S_WAIT_RX;
          end
        end
        S_WAIT_RX: begin
          if (rx_ready_i) begin
            state_d = cnt_zero ? S_DONE : S_RDATA;
          end
        end
        S_STOP: begin
          if (cmd_ack) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // outputs decoded from registered state only
  assign req_ready_o = req_ready_q;
  assign tx_ready_o  = (state_q == S_WAIT_TX);
  assign rx_valid_o  = (state_q == S_WAIT_RX);
  assign rx_data_o   = rxb_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign status_o    = status_q;

  assign bc_start_o = cmd_en && (state_q == S_ADDR);
  assign bc_write_o = cmd_en && ((state_q == S_ADDR) || (state_q == S_WDATA));
  assign bc_read_o  = cmd_en && (state_q == S_RDATA);
  assign bc_ack_o   = cmd_en && (state_q == S_RDATA) && cnt_last;
  assign bc_stop_o  = cmd_en && (((state_q == S_ADDR)  && cnt_zero) ||
                                 ((state_q == S_WDATA) && cnt_last) ||
                                 ((state_q == S_RDATA) && cnt_last) ||
                                  (state_q == S_STOP));
  assign bc_din_o   = !cmd_en                ? '0 :
                      (state_q == S_ADDR)    ? {addr_q, rnw_q} :
                      (state_q == S_WDATA)   ? txb_q : '0;

endmodule
